// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision constants, value classes and pipeline payloads.
// Guard/sticky payload fields exist only when FP_TO_INT_ROUND_NEAREST_EN is defined.
package fp_pkg;

    localparam int FP_EXP_W   = 8;
    localparam int FP_FRAC_W  = 23;
    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // Unpacked operand: exp is unbiased and only meaningful for FP_NORMAL.
    typedef struct packed {
        logic                     sign;
        fp_class_e                cls;
        logic [FP_FRAC_W:0]       mant;
        logic signed [FP_EXP_W:0] exp;
    } fp_s1_t;

    typedef struct packed {
        logic      sign;
        fp_class_e cls;
        logic      ovf;
        logic      inexact;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
        logic      guard;
        logic      sticky;
`endif
    } fp_s2_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack/classify of a single-precision word; denormals flush to zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic                     data_i_unused_guard,
    input  logic [31:0]              data_i,
    output logic                     sign_o,
    output logic [1:0]               cls_o,
    output logic [FP_FRAC_W:0]       mant_o,
    output logic signed [FP_EXP_W:0] exp_o
);

    localparam logic signed [FP_EXP_W:0] BIAS_S = (FP_EXP_W + 1)'(FP_BIAS);
    localparam logic [FP_EXP_W-1:0]      EXP_ALL1 = FP_EXP_W'(FP_EXP_MAX);

    logic [FP_EXP_W-1:0]  exp_raw;
    logic [FP_FRAC_W-1:0] frac;

    assign exp_raw = data_i[30:23];
    assign frac    = data_i[22:0];
    assign sign_o  = data_i[31] | (data_i_unused_guard & 1'b0);
    assign mant_o  = {1'b1, frac};
    assign exp_o   = $signed({1'b0, exp_raw}) - BIAS_S;

    always_comb begin
        if (exp_raw == EXP_ALL1) begin
            cls_o = (frac != '0) ? FP_NAN : FP_INF;
        end else if (exp_raw == '0) begin
            cls_o = FP_ZERO;
        end else begin
            cls_o = FP_NORMAL;
        end
    end

endmodule

// File: rtl/fp_to_int.sv
// Three-stage float-to-signed-integer converter with global-stall valid/ready flow.
// Optional build macro FP_TO_INT_ROUND_NEAREST_EN: round to nearest-even instead of truncating.
module fp_to_int
    import fp_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_invalid,
    output logic             out_inexact
);

    localparam int SHW   = $clog2(OUT_W);
    localparam int WIN_W = OUT_W + 47;
    localparam logic signed [FP_EXP_W:0] E_TOP = (FP_EXP_W + 1)'(OUT_W - 1);
    localparam logic signed [FP_EXP_W:0] E_M1  = '1;

    logic                     advance;
    logic                     vld_p1_q, vld_p2_q, vld_p3_q;
    fp_s1_t                   s1_d, s1_p1_q;
    fp_s2_t                   s2_d, s2_p2_q;
    logic [OUT_W-1:0]         mag_d, mag_p2_q;
    logic signed [OUT_W-1:0]  data_d, data_p3_q;
    logic                     inv_d, inv_p3_q, inx_d, inx_p3_q;

    logic                     sign_w;
    logic [1:0]               cls_w;
    logic [FP_FRAC_W:0]       mant_w;
    logic signed [FP_EXP_W:0] exp_w;
    logic signed [FP_EXP_W:0] e;
    logic [SHW-1:0]           sh;
    logic [WIN_W-1:0]         win;
    logic [OUT_W:0]           mag_r;

    assign advance  = ~vld_p3_q | out_ready;
    assign in_ready = advance;

    function automatic logic signed [OUT_W-1:0] sat_limit(input logic neg);
        sat_limit = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

`ifdef FP_TO_INT_ROUND_NEAREST_EN
    function automatic logic [OUT_W:0] round_rne(input logic [OUT_W-1:0] mag,
                                                 input logic guard, input logic sticky);
        round_rne = {1'b0, mag} + (OUT_W + 1)'(guard & (sticky | mag[0]));
    endfunction
`endif

    // Stage 1: unpack and classify
    fp_classify u_classify (
        .data_i_unused_guard (1'b0),
        .data_i              (in_data),
        .sign_o              (sign_w),
        .cls_o               (cls_w),
        .mant_o              (mant_w),
        .exp_o               (exp_w)
    );

    always_comb begin
        s1_d.sign = sign_w;
        s1_d.cls  = fp_class_e'(cls_w);
        s1_d.mant = mant_w;
        s1_d.exp  = exp_w;
    end

    // Stage 2: align the significand; the window keeps 47 fraction bits below the integer part
    always_comb begin
        e   = $signed(s1_p1_q.exp);
        sh  = e[SHW-1:0];
        win = {{(OUT_W-1){1'b0}}, s1_p1_q.mant, 24'b0} << sh;

        s2_d.sign    = s1_p1_q.sign;
        s2_d.cls     = s1_p1_q.cls;
        s2_d.ovf     = 1'b0;
        s2_d.inexact = 1'b0;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
        s2_d.guard   = 1'b0;
        s2_d.sticky  = 1'b0;
`endif
        mag_d        = '0;
        if (s1_p1_q.cls == FP_NORMAL) begin
            if (e[FP_EXP_W]) begin
                s2_d.inexact = 1'b1;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
                s2_d.guard   = (e == E_M1);
                s2_d.sticky  = (e != E_M1) | (|s1_p1_q.mant[FP_FRAC_W-1:0]);
`endif
            end else if ((e > E_TOP) ||
                         ((e == E_TOP) && !(s1_p1_q.sign && (s1_p1_q.mant[FP_FRAC_W-1:0] == '0)))) begin
                // -2^(OUT_W-1) exactly is the only representable value at this exponent
                s2_d.ovf = 1'b1;
            end else begin
                mag_d        = win[WIN_W-1:47];
                s2_d.inexact = |win[46:0];
`ifdef FP_TO_INT_ROUND_NEAREST_EN
                s2_d.guard   = win[46];
                s2_d.sticky  = |win[45:0];
`endif
            end
        end
    end

    // Stage 3: round, apply sign, saturate
    always_comb begin
`ifdef FP_TO_INT_ROUND_NEAREST_EN
        mag_r = round_rne(mag_p2_q, s2_p2_q.guard, s2_p2_q.sticky);
`else
        mag_r = {1'b0, mag_p2_q};
`endif
        data_d = '0;
        inv_d  = 1'b0;
        inx_d  = s2_p2_q.inexact;
        case (s2_p2_q.cls)
            FP_NAN: begin
                data_d = sat_limit(1'b0);
                inv_d  = 1'b1;
                inx_d  = 1'b0;
            end
            FP_INF: begin
                data_d = sat_limit(s2_p2_q.sign);
                inv_d  = 1'b1;
                inx_d  = 1'b0;
            end
            FP_ZERO: begin
                inx_d = 1'b0;
            end
            default: begin
                if (s2_p2_q.ovf || (!s2_p2_q.sign && (mag_r[OUT_W] | mag_r[OUT_W-1]))) begin
                    data_d = sat_limit(s2_p2_q.sign);
                    inv_d  = 1'b1;
                    inx_d  = 1'b0;
                end else if (s2_p2_q.sign) begin
                    data_d = -$signed(mag_r[OUT_W-1:0]);
                end else begin
                    data_d = $signed(mag_r[OUT_W-1:0]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else if (advance) begin
            vld_p1_q <= in_valid;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_p1_q   <= s1_d;
            s2_p2_q   <= s2_d;
            mag_p2_q  <= mag_d;
            data_p3_q <= data_d;
            inv_p3_q  <= inv_d;
            inx_p3_q  <= inx_d;
        end
    end

    // Data registers are not reset; the valid bit masks them at the port
    assign out_valid   = vld_p3_q;
    assign out_data    = vld_p3_q ? data_p3_q : '0;
    assign out_invalid = vld_p3_q & inv_p3_q;
    assign out_inexact = vld_p3_q & inx_p3_q;

endmodule

// File: tb/tb_fp_to_int.sv
// Bench for fp_to_int: real-arithmetic reference model with a scoreboard, plus directed vectors.
module tb_fp_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_inexact;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] d;
        logic        inv;
        logic        inx;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    fp_to_int #(.OUT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, expv);
        end
    endtask

    // Reference: exact real value of the float, then truncate (or round) and range-check
    function automatic void model(input logic [31:0] f, output logic [31:0] d,
                                  output logic inv, output logic inx);
        int     ex;
        real    mag, q, rem;
        longint qi;
        logic   s;
        s   = f[31];
        ex  = int'(f[30:23]);
        d   = 32'h0;
        inv = 1'b0;
        inx = 1'b0;
        if (ex == 255) begin
            inv = 1'b1;
            d   = ((f[22:0] != 23'h0) || !s) ? 32'h7FFFFFFF : 32'h80000000;
        end else if (ex != 0) begin
            mag = real'({1'b1, f[22:0]}) * (2.0 ** real'(ex - 150));
            q   = $floor(mag);
            rem = mag - q;
`ifdef FP_TO_INT_ROUND_NEAREST_EN
            if (rem > 0.5 || (rem == 0.5 && ($floor(q / 2.0) * 2.0 != q))) q = q + 1.0;
`endif
            if (!s && q > 2147483647.0) begin
                inv = 1'b1;
                d   = 32'h7FFFFFFF;
            end else if (s && q > 2147483648.0) begin
                inv = 1'b1;
                d   = 32'h80000000;
            end else begin
                qi  = longint'(q);
                if (s) qi = -qi;
                d   = qi[31:0];
                inx = (rem != 0.0);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got output 0x%08h, required no output", out_data);
                end else begin
                    mon_e = sbq.pop_front();
                    check("sb_data", out_data, mon_e.d);
                    check("sb_invalid", {31'b0, out_invalid}, {31'b0, mon_e.inv});
                    check("sb_inexact", {31'b0, out_inexact}, {31'b0, mon_e.inx});
                end
            end
            if (in_valid && in_ready) begin
                model(in_data, mon_e.d, mon_e.inv, mon_e.inx);
                sbq.push_back(mon_e);
            end
        end
    end

    task automatic run_one(input string name, input logic [31:0] f, input logic [31:0] ed,
                           input logic ei, input logic ex);
        logic [31:0] md;
        logic        mi, mx;
        int          lat;
        model(f, md, mi, mx);
        check({name, "_model"}, md, ed);
        check({name, "_model_flags"}, {30'b0, mi, mx}, {30'b0, ei, ex});
        in_valid  = 1'b1;
        in_data   = f;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd3);
        check({name, "_data"}, out_data, ed);
        check({name, "_flags"}, {30'b0, out_invalid, out_inexact}, {30'b0, ei, ex});
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bpv [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

    initial begin
        int   sent, got, stall;
        logic acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_flags", {30'b0, out_invalid, out_inexact}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        run_one("pi",        32'h40490FDB, 32'd3,        1'b0, 1'b1);
        run_one("neg123",    32'hC2F6E979, 32'hFFFFFF85, 1'b0, 1'b1);
        run_one("two24",     32'h4B800000, 32'h01000000, 1'b0, 1'b0);
        run_one("two31",     32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        run_one("neg_two31", 32'hCF000000, 32'h80000000, 1'b0, 1'b0);
        run_one("neg_ovf",   32'hCF000001, 32'h80000000, 1'b1, 1'b0);
        run_one("nan",       32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0);
        run_one("pos_inf",   32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0);
        run_one("neg_inf",   32'hFF800000, 32'h80000000, 1'b1, 1'b0);
        run_one("denorm",    32'h00000001, 32'd0,        1'b0, 1'b0);
        run_one("neg_zero",  32'h80000000, 32'd0,        1'b0, 1'b0);
`ifdef FP_TO_INT_ROUND_NEAREST_EN
        run_one("p2_5",      32'h40200000, 32'd2,        1'b0, 1'b1);
        run_one("p3_5",      32'h40600000, 32'd4,        1'b0, 1'b1);
        run_one("m1_5",      32'hBFC00000, 32'hFFFFFFFE, 1'b0, 1'b1);
        run_one("p0_5",      32'h3F000000, 32'd0,        1'b0, 1'b1);
        run_one("p0_75",     32'h3F400000, 32'd1,        1'b0, 1'b1);
`else
        run_one("p2_5",      32'h40200000, 32'd2,        1'b0, 1'b1);
        run_one("p3_5",      32'h40600000, 32'd3,        1'b0, 1'b1);
        run_one("m1_5",      32'hBFC00000, 32'hFFFFFFFF, 1'b0, 1'b1);
        run_one("p0_5",      32'h3F000000, 32'd0,        1'b0, 1'b1);
        run_one("p0_75",     32'h3F400000, 32'd0,        1'b0, 1'b1);
`endif

        // Backpressure: 1.0..4.0 back-to-back, output stalled 5 cycles after the first result
        sent  = 0;
        got   = 0;
        stall = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            out_ready = !(out_valid && got == 0 && stall < 5);
            in_valid  = (sent < 4);
            in_data   = (sent < 4) ? bpv[sent] : 32'h0;
            #1;
            if (!out_ready) begin
                stall++;
                check("bp_hold_data", out_data, 32'd1);
                check("bp_stall_in_ready", {31'b0, in_ready}, 32'd0);
            end
            if (out_valid && out_ready) begin
                check("bp_order", out_data, 32'(got + 1));
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 32'(got), 32'd4);
        check("bp_stall_cycles", 32'(stall), 32'd5);
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // Reset with three items in flight
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = bpv[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("rst_pre_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", {31'b0, out_valid}, 32'd0);
        check("rst_async_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("rst_no_stale", {31'b0, out_valid}, 32'd0);
        end
        run_one("post_rst", 32'h41200000, 32'd10, 1'b0, 1'b0);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
